// File: rtl/ibex_pkg.sv
// Shared PMP types for the requester arbiter: access-type and privilege encodings
// plus the request payload that travels through the check pipeline.
package ibex_pkg;

  typedef enum logic [1:0] {
    PMP_ACC_EXEC  = 2'b00,
    PMP_ACC_WRITE = 2'b01,
    PMP_ACC_READ  = 2'b10
  } pmp_req_e;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  localparam int unsigned PmpAddrW = 34;

  typedef struct packed {
    logic [PmpAddrW-1:0] addr;
    pmp_req_e            req_type;
    priv_lvl_e           priv;
  } pmp_arb_req_t;

  // Value the PMP channel sees out of reset.
  localparam pmp_arb_req_t PmpArbReqRst = '{addr: '0, req_type: PMP_ACC_EXEC, priv: PRIV_LVL_M};

endpackage

// File: rtl/ibex_pmp_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or after the pointer and
// moves the pointer just past the winner whenever the grant is taken.
module ibex_pmp_rr_arbiter #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      int unsigned cand;
      cand = int'(ptr_q) + off;
      if (cand >= NumReq) cand = cand - NumReq;
      if (grant_o == '0 && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = IdxW'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = (idx_o == IdxW'(NumReq - 1)) ? '0 : idx_o + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ibex_pmp_req_arb.sv
// Shares one PMP check channel among NumReq requesters: accept -> stage 1 (drives
// PMP) -> stage 2 (response). IBEX_PMP_ARB_PERF_CNT_EN adds per-requester stall counters.
module ibex_pmp_req_arb
  import ibex_pkg::*;
#(
  parameter int unsigned NumReq = 3,
  parameter int unsigned CntW   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic      [NumReq-1:0]         req_valid_i,
  output logic      [NumReq-1:0]         req_ready_o,
  input  logic      [NumReq-1:0][33:0]   req_addr_i,
  input  pmp_req_e  [NumReq-1:0]         req_type_i,
  input  priv_lvl_e [NumReq-1:0]         req_priv_i,
  input  logic      [NumReq-1:0]         flush_i,
  input  logic                           cfg_stall_i,
  output logic                           idle_o,
  output logic      [NumReq-1:0]         rsp_valid_o,
  output logic                           rsp_err_o,
  output logic      [33:0]               pmp_req_addr_o,
  output pmp_req_e                       pmp_req_type_o,
  output priv_lvl_e                      pmp_priv_mode_o,
  input  logic                           pmp_req_err_i,
  output logic      [NumReq-1:0][CntW-1:0] stall_cnt_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic [NumReq-1:0] grant;
  logic [IdxW-1:0]   grant_idx;
  logic              hs;

  logic              s1_valid_q, s1_valid_d;
  logic [IdxW-1:0]   s1_idx_q, s1_idx_d;
  pmp_arb_req_t      s1_req_q, s1_req_d;
  logic              s2_valid_q, s2_valid_d;
  logic [IdxW-1:0]   s2_idx_q, s2_idx_d;
  logic              s2_err_q, s2_err_d;

  ibex_pmp_rr_arbiter #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_valid_i),
    .en_i    (hs),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Ready is purely combinational; forced low while reset is asserted.
  assign req_ready_o = rst_i ? '0 : (grant & {NumReq{~cfg_stall_i}});
  assign hs          = |req_ready_o;

  always_comb begin
    s1_valid_d = hs;
    s1_idx_d   = s1_idx_q;
    s1_req_d   = s1_req_q;
    if (hs) begin
      s1_idx_d = grant_idx;
      s1_req_d = '{addr:     req_addr_i[grant_idx],
                   req_type: req_type_i[grant_idx],
                   priv:     req_priv_i[grant_idx]};
    end
    // A flush only kills the older entry; a same-cycle handshake still enters stage 1.
    s2_valid_d = s1_valid_q & ~flush_i[s1_idx_q];
    s2_idx_d   = s1_idx_q;
    s2_err_d   = pmp_req_err_i;
  end

  // NOTE: payload registers are reset too, because they drive the PMP channel
  // directly and must present defined encodings out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_req_q   <= PmpArbReqRst;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_req_q   <= s1_req_d;
      s2_valid_q <= s2_valid_d;
      s2_idx_q   <= s2_idx_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign pmp_req_addr_o  = s1_req_q.addr;
  assign pmp_req_type_o  = s1_req_q.req_type;
  assign pmp_priv_mode_o = s1_req_q.priv;
  assign idle_o          = ~s1_valid_q & ~s2_valid_q;

  always_comb begin
    rsp_valid_o = '0;
    if (s2_valid_q && !flush_i[s2_idx_q]) rsp_valid_o[s2_idx_q] = 1'b1;
  end
  assign rsp_err_o = (|rsp_valid_o) & s2_err_q;

`ifdef IBEX_PMP_ARB_PERF_CNT_EN
  logic [NumReq-1:0][CntW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (req_valid_i[k] && !req_ready_o[k] && stall_cnt_q[k] != '1) begin
        stall_cnt_d[k] = stall_cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_pmp_req_arb.sv
// Scoreboard bench for ibex_pmp_req_arb: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them against rsp_valid_o / rsp_err_o.
module tb_ibex_pmp_req_arb;
  import ibex_pkg::*;

  localparam int NumReq = 3;
  localparam int CntW   = 4;

  logic                       clk = 1'b0;
  logic                       rst_i;
  logic      [NumReq-1:0]     req_valid;
  logic      [NumReq-1:0]     req_ready;
  logic      [NumReq-1:0][33:0] req_addr;
  pmp_req_e  [NumReq-1:0]     req_type;
  priv_lvl_e [NumReq-1:0]     req_priv;
  logic      [NumReq-1:0]     flush;
  logic                       cfg_stall;
  logic                       idle;
  logic      [NumReq-1:0]     rsp_valid;
  logic                       rsp_err;
  logic      [33:0]           pmp_addr;
  pmp_req_e                   pmp_type;
  priv_lvl_e                  pmp_priv;
  logic                       pmp_err;
  logic      [NumReq-1:0][CntW-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    int   idx;
    logic err;
    int   cyc;
  } exp_t;
  exp_t exp_q[$];

  ibex_pmp_req_arb #(.NumReq(NumReq), .CntW(CntW)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_type_i      (req_type),
    .req_priv_i      (req_priv),
    .flush_i         (flush),
    .cfg_stall_i     (cfg_stall),
    .idle_o          (idle),
    .rsp_valid_o     (rsp_valid),
    .rsp_err_o       (rsp_err),
    .pmp_req_addr_o  (pmp_addr),
    .pmp_req_type_o  (pmp_type),
    .pmp_priv_mode_o (pmp_priv),
    .pmp_req_err_i   (pmp_err),
    .stall_cnt_o     (stall_cnt)
  );

  // PMP stand-in: addresses with bit 31 set fault.
  function automatic logic pmp_model(logic [33:0] a);
    return a[31];
  endfunction
  assign pmp_err = pmp_model(pmp_addr);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int idx, logic [33:0] a, int c);
    exp_q.push_back('{idx: idx, err: pmp_model(a), cyc: c});
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {61'd0, rsp_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_valid", {61'd0, rsp_valid}, 64'd1 << e.idx);
        check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        check("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (rsp_err !== 1'b0) begin
      check("rsp_err_idle", {63'd0, rsp_err}, 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NumReq-1:0][CntW-1:0] exp_cnt;
    rst_i     = 1'b1;
    req_valid = '1;
    flush     = '0;
    cfg_stall = 1'b0;
    req_addr  = '0;
    for (int k = 0; k < NumReq; k++) begin
      req_type[k] = PMP_ACC_EXEC;
      req_priv[k] = PRIV_LVL_M;
    end

    // Reset values, with all requesters valid to show ready is held low.
    repeat (2) next();
    @(negedge clk);
    check("rst_ready", {61'd0, req_ready}, 64'd0);
    check("rst_idle", {63'd0, idle}, 64'd1);
    check("rst_pmp_addr", {30'd0, pmp_addr}, 64'd0);
    check("rst_pmp_type", {62'd0, pmp_type}, {62'd0, PMP_ACC_EXEC});
    check("rst_pmp_priv", {62'd0, pmp_priv}, {62'd0, PRIV_LVL_M});
    check("rst_stall_cnt", {52'd0, stall_cnt}, 64'd0);
    next();
    rst_i     = 1'b0;
    req_valid = '0;
    next();

    // All three valid for six cycles: grants 0,1,2,0,1,2 through the pipeline.
    req_addr[0] = 34'h0_0000_1000; req_type[0] = PMP_ACC_EXEC;  req_priv[0] = PRIV_LVL_M;
    req_addr[1] = 34'h0_8000_0000; req_type[1] = PMP_ACC_READ;  req_priv[1] = PRIV_LVL_U;
    req_addr[2] = 34'h3_0000_2000; req_type[2] = PMP_ACC_WRITE; req_priv[2] = PRIV_LVL_S;
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_grant", {61'd0, req_ready}, 64'd1 << (i % 3));
      if (i > 0) check("rr_pmp_addr", {30'd0, pmp_addr}, {30'd0, req_addr[(i - 1) % 3]});
      if (i > 0) check("rr_idle_busy", {63'd0, idle}, 64'd0);
      push(i % 3, req_addr[i % 3], cyc + 2);
      next();
    end
    req_valid = '0;
    repeat (3) next();
    @(negedge clk);
    check("rr_idle_after", {63'd0, idle}, 64'd1);

    // Requester 1 alone: ready at once, PMP fields in cycle 1, faulting response in cycle 2.
    next();
    req_addr[1] = 34'h0_8000_0000; req_type[1] = PMP_ACC_READ; req_priv[1] = PRIV_LVL_U;
    req_valid   = 3'b010;
    @(negedge clk);
    check("r1_ready", {61'd0, req_ready}, 64'b010);
    push(1, req_addr[1], cyc + 2);
    next();
    req_valid = '0;
    @(negedge clk);
    check("r1_pmp_addr", {30'd0, pmp_addr}, 64'h0_8000_0000);
    check("r1_pmp_type", {62'd0, pmp_type}, {62'd0, PMP_ACC_READ});
    check("r1_pmp_priv", {62'd0, pmp_priv}, {62'd0, PRIV_LVL_U});
    repeat (3) next();

    // cfg_stall with one check in flight: no ready, response still delivered, then idle.
    req_addr[0] = 34'h1_8000_0040;
    req_valid   = 3'b001;
    @(negedge clk);
    check("stall_first_ready", {61'd0, req_ready}, 64'b001);
    push(0, req_addr[0], cyc + 2);
    next();
    cfg_stall = 1'b1;
    @(negedge clk);
    check("stall_ready_c1", {61'd0, req_ready}, 64'd0);
    check("stall_idle_c1", {63'd0, idle}, 64'd0);
    next();
    @(negedge clk);
    check("stall_ready_c2", {61'd0, req_ready}, 64'd0);
    next();
    @(negedge clk);
    check("stall_idle_c3", {63'd0, idle}, 64'd1);
    // Release; a flush of requester 0 with nothing older in flight must not kill the new one.
    next();
    cfg_stall   = 1'b0;
    flush       = 3'b001;
    req_addr[0] = 34'h0_0000_0500;
    @(negedge clk);
    check("stall_release_ready", {61'd0, req_ready}, 64'b001);
    push(0, req_addr[0], cyc + 2);
    next();
    req_valid = '0;
    flush     = '0;
    repeat (3) next();

    // Flush requester 1 during its cycle 1; concurrent requester 0 completes.
    req_addr[1] = 34'h0_8000_0100;
    req_valid   = 3'b010;
    @(negedge clk);
    check("fl_r1_ready", {61'd0, req_ready}, 64'b010);
    next();
    req_addr[0] = 34'h0_0000_0200;
    req_valid   = 3'b001;
    flush       = 3'b010;
    @(negedge clk);
    check("fl_r0_ready", {61'd0, req_ready}, 64'b001);
    check("fl_pmp_addr", {30'd0, pmp_addr}, 64'h0_8000_0100);
    push(0, req_addr[0], cyc + 2);
    next();
    req_valid = '0;
    flush     = '0;
    repeat (3) next();
    @(negedge clk);
    check("fl_idle", {63'd0, idle}, 64'd1);

    // Reset in cycle 1 of a check: outputs return to reset values at once, no response.
    next();
    req_addr[0] = 34'h2_0000_0300;
    req_valid   = 3'b001;
    @(negedge clk);
    check("rr_reset_ready", {61'd0, req_ready}, 64'b001);
    next();
    check("rr_reset_pre_addr", {30'd0, pmp_addr}, 64'h2_0000_0300);
    req_valid = 3'b111;
    rst_i     = 1'b1;
    #1;
    check("mid_rst_ready", {61'd0, req_ready}, 64'd0);
    check("mid_rst_idle", {63'd0, idle}, 64'd1);
    check("mid_rst_pmp_addr", {30'd0, pmp_addr}, 64'd0);
    check("mid_rst_pmp_type", {62'd0, pmp_type}, {62'd0, PMP_ACC_EXEC});
    check("mid_rst_pmp_priv", {62'd0, pmp_priv}, {62'd0, PRIV_LVL_M});
    check("mid_rst_rsp", {61'd0, rsp_valid}, 64'd0);
    repeat (2) next();
    rst_i     = 1'b0;
    req_valid = '0;
    repeat (4) next();
    @(negedge clk);
    check("post_rst_idle", {63'd0, idle}, 64'd1);

    // Requester 2 blocked by cfg_stall for 20 cycles: counter saturates at 15 when enabled.
    next();
    cfg_stall = 1'b1;
    req_valid = 3'b100;
    repeat (5) next();
    @(negedge clk);
    exp_cnt = '0;
`ifdef IBEX_PMP_ARB_PERF_CNT_EN
    exp_cnt[2] = 4'd5;
`endif
    check("stall_cnt_5", {52'd0, stall_cnt}, {52'd0, exp_cnt});
    check("stall_cnt_ready", {61'd0, req_ready}, 64'd0);
    repeat (15) next();
    @(negedge clk);
    exp_cnt = '0;
`ifdef IBEX_PMP_ARB_PERF_CNT_EN
    exp_cnt[2] = 4'd15;
`endif
    check("stall_cnt_sat", {52'd0, stall_cnt}, {52'd0, exp_cnt});
    next();
    req_valid = '0;
    cfg_stall = 1'b0;
    repeat (3) next();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
